// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART transmit/receive blocks.
//   - state_e        : transmitter frame state (PARITY only with UART_TX_PARITY_EN)
//   - XON / XOFF     : software flow-control characters
//   - UART_DATA_BITS : data bits per frame
// Build macro: UART_TX_PARITY_EN adds the even-parity state.
package uart_pkg;

  localparam int         UART_DATA_BITS = 8;
  localparam logic [7:0] XON            = 8'h11;
  localparam logic [7:0] XOFF           = 8'h13;

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_e;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_e;
`endif

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: bit-time generator shared by the UART transmitter/receiver.
// Down-counter reloaded with CLOCKS_PER_BAUD-1; tick is high for the one
// cycle the count is zero, so ticks are CLOCKS_PER_BAUD cycles apart.
// Ports:
//   clock, reset : clock, async active-high reset (count resets to 0)
//   clear        : restart the bit time; the next tick lands CLOCKS_PER_BAUD
//                  cycles after the clearing edge
//   tick         : one-cycle pulse at the end of each bit time
module uart_baud_tick #(
  parameter int CLOCKS_PER_BAUD = 104,
  parameter int COUNTER_BITS    = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic tick
);

  localparam logic [COUNTER_BITS-1:0] LOAD = COUNTER_BITS'(CLOCKS_PER_BAUD - 1);

  logic [COUNTER_BITS-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q - 1'b1;
    if (clear || cnt_q == '0) cnt_d = LOAD;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // A clearing cycle never counts as the end of a bit.
  assign tick = (cnt_q == '0) && !clear;

endmodule

// File: rtl/uart_tx_flow.sv
// uart_tx_flow: 8N1 UART transmitter (LSB first) with XON/XOFF flow control.
// Build macro: UART_TX_PARITY_EN inserts an even-parity bit after bit 7 (8E1).
// Ports:
//   clock, reset          : clock, async active-high reset
//   data_i/valid_i/ready_o: byte input handshake, transfer on valid&&ready
//   rx_data_i/rx_valid_i  : decoded bytes from the companion receiver;
//                           XOFF pauses, XON resumes
//   tx_o                  : registered serial line, idles high
//   busy_o                : frame in progress
//   paused_o              : XOFF in effect (frames in flight still finish)
module uart_tx_flow
  import uart_pkg::*;
#(
  parameter int CLOCKS_PER_BAUD = 104,
  parameter int COUNTER_BITS    = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [UART_DATA_BITS-1:0] data_i,
  input  logic                      valid_i,
  output logic                      ready_o,
  input  logic [7:0]                rx_data_i,
  input  logic                      rx_valid_i,
  output logic                      tx_o,
  output logic                      busy_o,
  output logic                      paused_o
);

  localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

  state_e                    state_q, state_d;
  logic [UART_DATA_BITS-1:0] shift_q, shift_d;
  logic [2:0]                bit_idx_q, bit_idx_d;
  logic                      paused_q, paused_d;
  logic                      tx_q, tx_d;
  logic                      accept, tick;
`ifdef UART_TX_PARITY_EN
  logic                      parity_q, parity_d;
`endif

  assign ready_o  = (state_q == ST_IDLE) && !paused_q;
  assign accept   = valid_i && ready_o;
  assign busy_o   = (state_q != ST_IDLE);
  assign paused_o = paused_q;
  assign tx_o     = tx_q;

  uart_baud_tick #(
    .CLOCKS_PER_BAUD(CLOCKS_PER_BAUD),
    .COUNTER_BITS   (COUNTER_BITS)
  ) u_baud (
    .clock(clock),
    .reset(reset),
    .clear(accept),
    .tick (tick)
  );

  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_idx_d = bit_idx_q;
`ifdef UART_TX_PARITY_EN
    parity_d  = parity_q;
`endif
    if (accept) begin
      state_d   = ST_START;
      shift_d   = data_i;
      bit_idx_d = '0;
`ifdef UART_TX_PARITY_EN
      parity_d  = ^data_i;
`endif
    end else if (tick) begin
      case (state_q)
        ST_START: state_d = ST_DATA;
        ST_DATA: begin
          // Index wraps back to 0 after the last bit, ready for the next frame.
          bit_idx_d = bit_idx_q + 3'd1;
          if (bit_idx_q == LAST_BIT) begin
`ifdef UART_TX_PARITY_EN
            state_d = ST_PARITY;
`else
            state_d = ST_STOP;
`endif
          end else begin
            shift_d = shift_q >> 1;
          end
        end
`ifdef UART_TX_PARITY_EN
        ST_PARITY: state_d = ST_STOP;
`endif
        ST_STOP:  state_d = ST_IDLE;
        default:  state_d = state_q;
      endcase
    end
  end

  // Line level is decoded from the next state so tx_o changes on the same
  // edge as the state, straight from a flop.
  always_comb begin
    case (state_d)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_d = parity_d;
`endif
      default:   tx_d = 1'b1;
    endcase
  end

  always_comb begin
    paused_d = paused_q;
    if (rx_valid_i) begin
      if (rx_data_i == XOFF)     paused_d = 1'b1;
      else if (rx_data_i == XON) paused_d = 1'b0;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      shift_q   <= '0;
      bit_idx_q <= '0;
      paused_q  <= 1'b0;
      tx_q      <= 1'b1;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_idx_q <= bit_idx_d;
      paused_q  <= paused_d;
      tx_q      <= tx_d;
    end
  end

`ifdef UART_TX_PARITY_EN
  always_ff @(posedge clock or posedge reset) begin
    if (reset) parity_q <= 1'b0;
    else       parity_q <= parity_d;
  end
`endif

endmodule

// File: tb/tb_uart_tx_flow.sv
// tb_uart_tx_flow: directed bench for uart_tx_flow at CLOCKS_PER_BAUD = 4.
// A frame-timing model predicts tx/busy/ready/paused from the accept time,
// the byte and the XON/XOFF history; a line receiver decodes tx_o.
module tb_uart_tx_flow;
  import uart_pkg::*;

  localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
  localparam int NB = 11;
`else
  localparam int NB = 10;
`endif
  localparam int FRAME = NB * CPB;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] data_i, rx_data_i;
  logic       valid_i, rx_valid_i;
  logic       ready_o, tx_o, busy_o, paused_o;

  int total = 0, bad = 0, cyc = 0;
  int acc_cyc = 0;

  always #5 clock = ~clock;

  uart_tx_flow #(.CLOCKS_PER_BAUD(CPB), .COUNTER_BITS(8)) dut (
    .clock(clock), .reset(reset),
    .data_i(data_i), .valid_i(valid_i), .ready_o(ready_o),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i),
    .tx_o(tx_o), .busy_o(busy_o), .paused_o(paused_o)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Level of frame bit k (0 = start) for byte b.
  function automatic logic bitval(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k <= 8) return b[k-1];
    if (NB == 11 && k == 9) return ^b;
    return 1'b1;
  endfunction

  // Model: m_t = cycles since the accept edge (0 = idle).
  int         m_t = 0;
  logic [7:0] m_byte = 8'h00;
  logic       m_paused = 1'b0;

  always @(posedge clock) begin
    cyc++;
    if (reset) begin
      m_t = 0; m_paused = 1'b0;
    end else begin
      logic acc;
      acc = valid_i && (m_t == 0) && !m_paused;
      if (m_t != 0) m_t = (m_t == FRAME) ? 0 : m_t + 1;
      if (acc) begin m_t = 1; m_byte = data_i; end
      if (rx_valid_i && rx_data_i == XOFF)     m_paused = 1'b1;
      else if (rx_valid_i && rx_data_i == XON) m_paused = 1'b0;
    end
  end

  // Compare against the model and decode the line every cycle.
  logic [7:0] dec_q[$];
  logic [7:0] rx_sh = 8'h00;
  bit         rx_busy = 1'b0;
  int         rx_cnt = 0;

  always @(negedge clock) begin
    if (reset) begin
      rx_busy = 1'b0;
    end else begin
      chk("cyc_busy",   busy_o,   m_t != 0);
      chk("cyc_ready",  ready_o,  (m_t == 0) && !m_paused);
      chk("cyc_paused", paused_o, m_paused);
      chk("cyc_tx",     tx_o,     (m_t == 0) ? 1'b1 : bitval(m_byte, (m_t - 1) / CPB));
      if (!rx_busy) begin
        if (tx_o == 1'b0) begin rx_busy = 1'b1; rx_cnt = 0; end
      end else begin
        rx_cnt++;
        if (rx_cnt % CPB == CPB / 2) begin
          int k;
          k = rx_cnt / CPB;
          if (k <= 8) rx_sh[k-1] = tx_o;
          else if (k == NB - 1) begin
            chk("rx_stop", tx_o, 1);
            dec_q.push_back(rx_sh);
            rx_busy = 1'b0;
          end else chk("rx_parity", tx_o, ^rx_sh);
        end
      end
    end
  end

  // Call at a negedge; returns at the negedge after the accept, valid_i still high.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    data_i = b; valid_i = 1'b1;
    while (!ready_o && n < 200) begin @(negedge clock); n++; end
    if (!ready_o) chk("send_timeout", 0, 1);
    else acc_cyc = cyc + 1;
    @(negedge clock);
  endtask

  task automatic rx_pulse(input logic [7:0] b);
    rx_data_i = b; rx_valid_i = 1'b1;
    @(negedge clock);
    rx_valid_i = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [10:0] p55;
    logic [7:0]  exp_q[$];
    int          nbusy, a1, a2, xon_cyc;
`ifdef UART_TX_PARITY_EN
    p55 = 11'b10010101010;
`else
    p55 = 11'b01010101010;
`endif
    valid_i = 0; data_i = 0; rx_valid_i = 0; rx_data_i = 0;
    repeat (2) @(negedge clock);
    chk("rst_tx", tx_o, 1);
    chk("rst_busy", busy_o, 0);
    chk("rst_ready", ready_o, 1);
    chk("rst_paused", paused_o, 0);
    #2 reset = 1'b0;
    @(negedge clock);

    // 0x55 waveform, literal pattern
    send_byte(8'h55); valid_i = 1'b0; exp_q.push_back(8'h55);
    nbusy = 0;
    for (int i = 0; i < FRAME; i++) begin
      chk("t1_tx", tx_o, p55[i/CPB]);
      if (busy_o) nbusy++;
      @(negedge clock);
    end
    chk("t1_busy_len", nbusy, FRAME);
    chk("t1_busy_end", busy_o, 0);
    chk("t1_ready_back", ready_o, 1);

    // back-to-back with valid held
    send_byte(8'h41); a1 = acc_cyc;
    send_byte(8'h42); a2 = acc_cyc; valid_i = 1'b0;
    exp_q.push_back(8'h41); exp_q.push_back(8'h42);
    chk("t2_period", a2 - a1, FRAME + 1);
    repeat (FRAME + 2) @(negedge clock);

    // XOFF mid-frame, then XON
    send_byte(8'hA5); valid_i = 1'b0; exp_q.push_back(8'hA5);
    repeat (10) @(negedge clock);
    rx_pulse(XOFF);
    chk("t3_paused", paused_o, 1);
    chk("t3_ready_low", ready_o, 0);
    data_i = 8'h3C; valid_i = 1'b1;
    repeat (FRAME) @(negedge clock);
    chk("t3_done", busy_o, 0);
    chk("t3_held", ready_o, 0);
    xon_cyc = cyc + 1;
    rx_pulse(XON);
    send_byte(8'h3C); valid_i = 1'b0; exp_q.push_back(8'h3C);
    chk("t3_resume", acc_cyc - xon_cyc, 1);
    repeat (FRAME + 2) @(negedge clock);

    // XOFF in the accept cycle
    chk("t4_ready_pre", ready_o, 1);
    data_i = 8'h00; valid_i = 1'b1; rx_data_i = XOFF; rx_valid_i = 1'b1;
    @(negedge clock);
    rx_valid_i = 1'b0; data_i = 8'h77; exp_q.push_back(8'h00);
    chk("t4_busy", busy_o, 1);
    chk("t4_paused", paused_o, 1);
    repeat (FRAME + 20) @(negedge clock);
    chk("t4_idle", busy_o, 0);
    chk("t4_no_accept", ready_o, 0);
    rx_pulse(XON);
    send_byte(8'h77); valid_i = 1'b0; exp_q.push_back(8'h77);
    repeat (FRAME + 2) @(negedge clock);

    // async reset during data bit 3
    send_byte(8'hFF); valid_i = 1'b0;
    repeat (17) @(negedge clock);
    #2 reset = 1'b1;
    #1 chk("t5_tx", tx_o, 1);
    chk("t5_busy", busy_o, 0);
    @(negedge clock); #2 reset = 1'b0;
    @(negedge clock);
    send_byte(8'h00); valid_i = 1'b0;
    repeat (17) @(negedge clock);
    chk("t5b_pre", tx_o, 0);
    #2 reset = 1'b1;
    #1 chk("t5b_tx", tx_o, 1);
    chk("t5b_busy", busy_o, 0);
    chk("t5b_ready", ready_o, 1);
    @(negedge clock); #2 reset = 1'b0;
    @(negedge clock);
    send_byte(8'h5A); valid_i = 1'b0; exp_q.push_back(8'h5A);
    repeat (FRAME + 2) @(negedge clock);

`ifdef UART_TX_PARITY_EN
    send_byte(8'h07); valid_i = 1'b0; exp_q.push_back(8'h07);
    repeat (9 * CPB + CPB / 2 - 1) @(negedge clock);
    chk("par_07", tx_o, 1);
    repeat (FRAME) @(negedge clock);
    send_byte(8'h03); valid_i = 1'b0; exp_q.push_back(8'h03);
    repeat (9 * CPB + CPB / 2 - 1) @(negedge clock);
    chk("par_03", tx_o, 0);
    repeat (FRAME) @(negedge clock);
`endif

    chk("rx_count", dec_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < dec_q.size(); i++)
      chk("rx_byte", dec_q[i], exp_q[i]);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
